alarma_multicanal: RTL and testbench

Parametrised multi-channel alarm unit that replaces the single-alarm flag path between the keyboard/register front end and the RTC display/buzzer outputs. Stores CANALES independent BCD alarm times, compares each against the live RTC time, and raises per-channel ringing state with automatic timeout, acknowledge, and an optional snooze. Drives the buzzer pattern byte and the VGA alarm flag.

---
 rtl/alarma_multicanal.sv | 186 ++++++++++++++++++
 tb/tb_alarma_multicanal.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alarma_multicanal.sv
// alarma_multicanal: CANALES independent BCD alarm channels compared against the
// live RTC time, with per-channel ringing, automatic timeout, global stop and an
// optional snooze (compiled in with `define ALARMA_POSPONER_EN).
//
// Ports:
//   clk, reset                     clock, asynchronous active-low reset
//   cargar, canal_sel, hab_in      load strobe, target channel, enable to write
//   seg_in, min_in, hor_in         BCD alarm time to load
//   seg_rtc, min_rtc, hor_rtc      BCD live RTC time
//   apagar                         stop every ringing/snoozed channel
//   posponer                       snooze every ringing channel (macro only)
//   sonando                        per-channel ringing (registered)
//   canal_activo                   lowest-index ringing channel, 0 when none
//   flag_vga                       any channel ringing
//   flag_pico                      buzzer pattern byte
//   carga_err                      one-cycle pulse on a rejected load
module alarma_multicanal #(
   parameter int unsigned CANALES      = 4,
   parameter int unsigned CW           = (CANALES > 1) ? $clog2(CANALES) : 1,
   parameter int unsigned DURACION_SEG = 60,
   parameter int unsigned POSPONER_SEG = 300
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               cargar,
   input  logic [CW-1:0]      canal_sel,
   input  logic               hab_in,
   input  logic [7:0]         seg_in,
   input  logic [7:0]         min_in,
   input  logic [7:0]         hor_in,
   input  logic [7:0]         seg_rtc,
   input  logic [7:0]         min_rtc,
   input  logic [7:0]         hor_rtc,
   input  logic               apagar,
   input  logic               posponer,
   output logic [CANALES-1:0] sonando,
   output logic [CW-1:0]      canal_activo,
   output logic               flag_vga,
   output logic [7:0]         flag_pico,
   output logic               carga_err
);

`ifdef ALARMA_POSPONER_EN
   localparam int unsigned CNT_MAX = (POSPONER_SEG > DURACION_SEG) ? POSPONER_SEG : DURACION_SEG;
   typedef enum logic [1:0] {IDLE, ARMADO, SONANDO, POSPUESTO} estado_t;
`else
   localparam int unsigned CNT_MAX = DURACION_SEG;
   typedef enum logic [1:0] {IDLE, ARMADO, SONANDO} estado_t;
`endif
   localparam int unsigned CNT_W = $clog2(CNT_MAX + 1);

   typedef struct packed {
      logic [7:0] hor;
      logic [7:0] min;
      logic [7:0] seg;
   } hora_t;

   hora_t              alarma_q [CANALES];
   hora_t              rtc_c;
   estado_t            estado_q [CANALES];
   estado_t            estado_d [CANALES];
   logic [CNT_W-1:0]   cnt_q    [CANALES];
   logic [CNT_W-1:0]   cnt_d    [CANALES];
   logic [CANALES-1:0] igual_c, igual_q, igual_p, flanco_c, carga_c, sonando_d;
   logic [7:0]         seg_prev_q, flag_pico_d;
   logic               tick_c, carga_ok_c;

`ifndef ALARMA_POSPONER_EN
   // Snooze input and length have no function in this build.
   logic unused_cfg;
   assign unused_cfg = posponer | (POSPONER_SEG == 0);
`endif

   assign rtc_c    = {hor_rtc, min_rtc, seg_rtc};
   assign tick_c   = (seg_rtc != seg_prev_q);
   // igual_q holds this cycle's registered compare, igual_p the one before it.
   assign flanco_c = igual_q & ~igual_p;
   assign flag_vga = |sonando;

   // Load is accepted only for a real channel and a legal BCD time.
   assign carga_ok_c = (32'(canal_sel) < CANALES)
                     && (seg_in <= 8'h59) && (seg_in[3:0] <= 4'd9)
                     && (min_in <= 8'h59) && (min_in[3:0] <= 4'd9)
                     && (hor_in <= 8'h23) && (hor_in[3:0] <= 4'd9);

   // Per-channel live compare and load decode.
   always_comb begin
      igual_c = '0;
      carga_c = '0;
      for (int i = 0; i < CANALES; i++) begin
         igual_c[i] = (alarma_q[i] == rtc_c);
         carga_c[i] = cargar && carga_ok_c && (canal_sel == CW'(i));
      end
   end

   // Channel next state: load > apagar > posponer > timeout/match.
   always_comb begin
      sonando_d = '0;
      for (int i = 0; i < CANALES; i++) begin
         estado_d[i] = estado_q[i];
         cnt_d[i]    = cnt_q[i];
         if (carga_c[i]) begin
            estado_d[i] = hab_in ? ARMADO : IDLE;
            cnt_d[i]    = '0;
         end else if (apagar) begin
            if (estado_q[i] != IDLE) estado_d[i] = ARMADO;
`ifdef ALARMA_POSPONER_EN
         end else if (posponer && (estado_q[i] == SONANDO)) begin
            estado_d[i] = POSPUESTO;
            cnt_d[i]    = '0;
`endif
         end else begin
            case (estado_q[i])
               ARMADO: begin
                  if (flanco_c[i]) begin
                     estado_d[i] = SONANDO;
                     cnt_d[i]    = '0;
                  end
               end
               SONANDO: begin
                  if (cnt_q[i] == CNT_W'(DURACION_SEG)) estado_d[i] = ARMADO;
                  else if (tick_c)                      cnt_d[i] = cnt_q[i] + CNT_W'(1);
               end
`ifdef ALARMA_POSPONER_EN
               POSPUESTO: begin
                  if (cnt_q[i] == CNT_W'(POSPONER_SEG)) begin
                     estado_d[i] = SONANDO;
                     cnt_d[i]    = '0;
                  end else if (tick_c) begin
                     cnt_d[i] = cnt_q[i] + CNT_W'(1);
                  end
               end
`endif
               default: ;
            endcase
         end
         sonando_d[i] = (estado_d[i] == SONANDO);
      end
   end

   // Buzzer pattern: all ones on first ring, toggles each second while ringing.
   always_comb begin
      flag_pico_d = flag_pico;
      if (sonando_d == '0)    flag_pico_d = 8'h00;
      else if (sonando == '0) flag_pico_d = 8'hFF;
      else if (tick_c)        flag_pico_d = ~flag_pico;
   end

   // Lowest-index ringing channel.
   always_comb begin
      canal_activo = '0;
      for (int i = int'(CANALES) - 1; i >= 0; i--) begin
         if (sonando[i]) canal_activo = CW'(i);
      end
   end

   // State, storage and output registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < CANALES; i++) begin
            estado_q[i] <= IDLE;
            cnt_q[i]    <= '0;
            alarma_q[i] <= '0;
         end
         igual_q    <= '0;
         igual_p    <= '0;
         seg_prev_q <= 8'h00;
         sonando    <= '0;
         flag_pico  <= 8'h00;
         carga_err  <= 1'b0;
      end else begin
         for (int i = 0; i < CANALES; i++) begin
            estado_q[i] <= estado_d[i];
            cnt_q[i]    <= cnt_d[i];
            if (carga_c[i]) alarma_q[i] <= {hor_in, min_in, seg_in};
         end
         igual_q    <= igual_c;
         igual_p    <= igual_q;
         seg_prev_q <= seg_rtc;
         sonando    <= sonando_d;
         flag_pico  <= flag_pico_d;
         carga_err  <= cargar && !carga_ok_c;
      end
   end

endmodule

// File: tb/tb_alarma_multicanal.sv
// Testbench for alarma_multicanal: directed scenarios followed by a random phase,
// every cycle checked against a cycle-level behavioural model of the alarm rules.
`timescale 1ns/1ps
module tb_alarma_multicanal;
   localparam int unsigned CAN = 4;
   localparam int unsigned CWB = 2;
   localparam int          DUR = 3;
   localparam int          POS = 2;
`ifdef ALARMA_POSPONER_EN
   localparam bit SNOOZE = 1'b1;
`else
   localparam bit SNOOZE = 1'b0;
`endif

   logic           clk = 1'b0;
   logic           reset;
   logic           cargar, hab_in, apagar, posponer;
   logic [CWB-1:0] canal_sel;
   logic [7:0]     seg_in, min_in, hor_in, seg_rtc, min_rtc, hor_rtc;
   logic [CAN-1:0] sonando;
   logic [CWB-1:0] canal_activo;
   logic           flag_vga, carga_err;
   logic [7:0]     flag_pico;

   alarma_multicanal #(.CANALES(CAN), .CW(CWB), .DURACION_SEG(DUR), .POSPONER_SEG(POS)) dut (
      .clk(clk), .reset(reset), .cargar(cargar), .canal_sel(canal_sel), .hab_in(hab_in),
      .seg_in(seg_in), .min_in(min_in), .hor_in(hor_in),
      .seg_rtc(seg_rtc), .min_rtc(min_rtc), .hor_rtc(hor_rtc),
      .apagar(apagar), .posponer(posponer),
      .sonando(sonando), .canal_activo(canal_activo), .flag_vga(flag_vga),
      .flag_pico(flag_pico), .carga_err(carga_err));

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;

   // Model: mode 0 off, 1 armed, 2 ringing, 3 snoozed; seconds counted per channel.
   int             m_modo [CAN];
   int             m_cnt  [CAN];
   logic [23:0]    m_hora [CAN];
   bit             m_eq1  [CAN];
   bit             m_eq2  [CAN];
   logic [7:0]     m_seg_prev, m_pico;
   logic [CAN-1:0] exp_son;
   logic [CWB-1:0] exp_act;
   logic           exp_err;

   logic [7:0] pool_h [5] = '{8'h07, 8'h12, 8'h08, 8'h12, 8'h07};
   logic [7:0] pool_m [5] = '{8'h30, 8'h00, 8'h00, 8'h00, 8'h29};
   logic [7:0] pool_s [5] = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h59};

   function automatic bit campo_ok(input logic [7:0] v, input int lim);
      int hi = int'(v[7:4]);
      int lo = int'(v[3:0]);
      return (lo < 10) && ((hi * 10 + lo) <= lim);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_chk++;
      assert (obs === exp_v) n_pass++;
      else $error("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
   endtask

   task automatic model_reset();
      for (int c = 0; c < CAN; c++) begin
         m_modo[c] = 0; m_cnt[c] = 0; m_hora[c] = '0; m_eq1[c] = 0; m_eq2[c] = 0;
      end
      m_seg_prev = 8'h00; m_pico = 8'h00; exp_son = '0; exp_act = '0; exp_err = 1'b0;
   endtask

   // Advance the model by the clock edge that ends the current cycle.
   task automatic model_step();
      bit tick, ok, antes, flanco;
      logic [23:0] ahora;
      logic [CAN-1:0] son_n;
      if (!reset) begin
         model_reset();
         return;
      end
      ahora = {hor_rtc, min_rtc, seg_rtc};
      tick  = (seg_rtc != m_seg_prev);
      ok    = campo_ok(seg_in, 59) && campo_ok(min_in, 59) && campo_ok(hor_in, 23)
              && (int'(canal_sel) < int'(CAN));
      antes = (exp_son != '0);
      son_n = '0;
      for (int c = 0; c < CAN; c++) begin
         flanco = m_eq1[c] && !m_eq2[c];
         m_eq2[c] = m_eq1[c];
         m_eq1[c] = (m_hora[c] == ahora);
         if (cargar && ok && (int'(canal_sel) == c)) begin
            m_hora[c] = {hor_in, min_in, seg_in};
            m_modo[c] = hab_in ? 1 : 0;
         end else if (apagar) begin
            if (m_modo[c] >= 2) m_modo[c] = 1;
         end else if (SNOOZE && posponer && m_modo[c] == 2) begin
            m_modo[c] = 3; m_cnt[c] = 0;
         end else if (m_modo[c] == 1 && flanco) begin
            m_modo[c] = 2; m_cnt[c] = 0;
         end else if (m_modo[c] == 2) begin
            if (m_cnt[c] == DUR) m_modo[c] = 1;
            else if (tick) m_cnt[c]++;
         end else if (m_modo[c] == 3) begin
            if (m_cnt[c] == POS) begin m_modo[c] = 2; m_cnt[c] = 0; end
            else if (tick) m_cnt[c]++;
         end
         son_n[c] = (m_modo[c] == 2);
      end
      exp_act = '0;
      for (int c = 0; c < CAN; c++) begin
         if (son_n[c]) begin exp_act = CWB'(c); break; end
      end
      if (son_n == '0) m_pico = 8'h00;
      else if (!antes) m_pico = 8'hFF;
      else if (tick)   m_pico = ~m_pico;
      exp_son    = son_n;
      exp_err    = cargar && !ok;
      m_seg_prev = seg_rtc;
   endtask

   task automatic chk_all();
      chk("sonando",      32'(sonando),      32'(exp_son));
      chk("canal_activo", 32'(canal_activo), 32'(exp_act));
      chk("flag_vga",     32'(flag_vga),     32'(exp_son != '0));
      chk("flag_pico",    32'(flag_pico),    32'(m_pico));
      chk("carga_err",    32'(carga_err),    32'(exp_err));
   endtask

   task automatic paso();
      model_step();
      @(posedge clk);
      #1;
      chk_all();
   endtask

   task automatic set_rtc(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
      hor_rtc = h; min_rtc = m; seg_rtc = s;
   endtask

   task automatic carga(input int ch, input bit en, input logic [7:0] h,
                        input logic [7:0] m, input logic [7:0] s);
      cargar = 1'b1; canal_sel = CWB'(ch); hab_in = en;
      hor_in = h; min_in = m; seg_in = s;
      paso();
      cargar = 1'b0;
   endtask

   initial begin
      reset = 1'b0; cargar = 1'b0; hab_in = 1'b0; apagar = 1'b0; posponer = 1'b0;
      canal_sel = '0; seg_in = '0; min_in = '0; hor_in = '0;
      set_rtc(8'h00, 8'h00, 8'h00);
      model_reset();

      // Reset state
      paso(); paso();
      chk("reset sonando", 32'(sonando), 32'h0);
      chk("reset pico", 32'(flag_pico), 32'h00);
      reset = 1'b1;

      // Single channel ring, pattern and timeout
      set_rtc(8'h07, 8'h29, 8'h59); paso();
      carga(2, 1'b1, 8'h07, 8'h30, 8'h00);
      paso();
      set_rtc(8'h07, 8'h30, 8'h00); paso();
      chk("ch2 not yet", 32'(sonando), 32'h0);
      paso();
      chk("ch2 rings", 32'(sonando), 32'b0100);
      chk("ch2 activo", 32'(canal_activo), 32'd2);
      chk("ch2 pico ff", 32'(flag_pico), 32'hFF);
      set_rtc(8'h07, 8'h30, 8'h01); paso();
      chk("pico toggles", 32'(flag_pico), 32'h00);
      set_rtc(8'h07, 8'h30, 8'h02); paso();
      set_rtc(8'h07, 8'h30, 8'h03); paso();
      chk("ch2 still ringing", 32'(sonando), 32'b0100);
      paso();
      chk("ch2 timeout", 32'(sonando), 32'h0);

      // Timeout with RTC back on the alarm time: no retrigger
      set_rtc(8'h07, 8'h59, 8'h59); paso();
      carga(0, 1'b1, 8'h08, 8'h00, 8'h00);
      set_rtc(8'h08, 8'h00, 8'h00); paso(); paso();
      chk("ch0 rings", 32'(sonando), 32'b0001);
      set_rtc(8'h08, 8'h00, 8'h01); paso();
      set_rtc(8'h08, 8'h00, 8'h02); paso();
      set_rtc(8'h08, 8'h00, 8'h00); paso();
      chk("ch0 last tick", 32'(sonando), 32'b0001);
      for (int k = 0; k < 5; k++) begin
         paso();
         chk("ch0 no retrigger", 32'(sonando), 32'h0);
      end

      // Two channels together, then stop
      set_rtc(8'h11, 8'h59, 8'h59); paso();
      carga(1, 1'b1, 8'h12, 8'h00, 8'h00);
      carga(3, 1'b1, 8'h12, 8'h00, 8'h00);
      set_rtc(8'h12, 8'h00, 8'h00); paso(); paso();
      chk("ch1+ch3 ring", 32'(sonando), 32'b1010);
      chk("ch1 activo", 32'(canal_activo), 32'd1);
      apagar = 1'b1; paso(); apagar = 1'b0;
      chk("apagar sonando", 32'(sonando), 32'h0);
      chk("apagar pico", 32'(flag_pico), 32'h00);

      // Rejected loads leave the stored time intact
      carga(1, 1'b1, 8'h12, 8'h00, 8'h60);
      chk("err seg 60", 32'(carga_err), 32'd1);
      paso();
      chk("err pulse ends", 32'(carga_err), 32'd0);
      carga(1, 1'b1, 8'h24, 8'h00, 8'h00);
      chk("err hor 24", 32'(carga_err), 32'd1);
      carga(1, 1'b1, 8'h12, 8'h3A, 8'h00);
      chk("err min 3A", 32'(carga_err), 32'd1);
      set_rtc(8'h11, 8'h00, 8'h00); paso();
      set_rtc(8'h12, 8'h00, 8'h00); paso(); paso();
      chk("stored kept", 32'(sonando), 32'b1010);
      carga(1, 1'b0, 8'h12, 8'h00, 8'h00);
      chk("disable silences", 32'(sonando), 32'b1000);
      set_rtc(8'h11, 8'h00, 8'h00); paso();
      set_rtc(8'h12, 8'h00, 8'h00); paso(); paso(); paso();
      chk("ch1 silent", 32'(sonando[1]), 32'd0);
      apagar = 1'b1; paso(); apagar = 1'b0;

`ifdef ALARMA_POSPONER_EN
      // Snooze and re-ring, then stop+snooze together
      set_rtc(8'h07, 8'h59, 8'h59); paso();
      set_rtc(8'h08, 8'h00, 8'h00); paso(); paso();
      chk("snz ring", 32'(sonando), 32'b0001);
      posponer = 1'b1; paso(); posponer = 1'b0;
      chk("snz quiet", 32'(sonando), 32'h0);
      set_rtc(8'h08, 8'h00, 8'h01); paso();
      set_rtc(8'h08, 8'h00, 8'h02); paso();
      chk("snz still quiet", 32'(sonando), 32'h0);
      paso();
      chk("snz re-ring", 32'(sonando), 32'b0001);
      apagar = 1'b1; posponer = 1'b1; paso(); apagar = 1'b0; posponer = 1'b0;
      chk("apagar over posponer", 32'(sonando), 32'h0);
      for (int k = 3; k < 6; k++) begin
         set_rtc(8'h08, 8'h00, 8'(k)); paso();
         chk("no re-ring", 32'(sonando), 32'h0);
      end
`endif

      // Random phase against the model
      for (int k = 0; k < 400; k++) begin
         int p;
         int q;
         if ($urandom_range(3) == 0) begin
            p = int'($urandom_range(4));
            set_rtc(pool_h[p], pool_m[p], pool_s[p]);
         end
         cargar = ($urandom_range(11) == 0);
         if (cargar) begin
            q = int'($urandom_range(4));
            canal_sel = CWB'($urandom_range(CAN - 1));
            hab_in    = 1'($urandom_range(1));
            hor_in    = ($urandom_range(5) == 0) ? 8'($urandom()) : pool_h[q];
            min_in    = ($urandom_range(5) == 0) ? 8'($urandom()) : pool_m[q];
            seg_in    = ($urandom_range(5) == 0) ? 8'($urandom()) : pool_s[q];
         end
         apagar   = ($urandom_range(19) == 0);
         posponer = ($urandom_range(19) == 0);
         paso();
      end
      cargar = 1'b0; apagar = 1'b0; posponer = 1'b0;

      // Asynchronous reset while ringing
      apagar = 1'b1; set_rtc(8'h08, 8'h59, 8'h59); paso(); apagar = 1'b0;
      carga(0, 1'b1, 8'h09, 8'h00, 8'h00);
      set_rtc(8'h09, 8'h00, 8'h00); paso(); paso();
      chk("pre-reset ring", 32'(sonando[0]), 32'd1);
      #2 reset = 1'b0;
      #1;
      model_reset();
      chk("async sonando", 32'(sonando), 32'h0);
      chk("async activo", 32'(canal_activo), 32'h0);
      chk("async vga", 32'(flag_vga), 32'h0);
      chk("async pico", 32'(flag_pico), 32'h00);
      chk("async err", 32'(carga_err), 32'h0);
      paso();
      reset = 1'b1;
      set_rtc(8'h08, 8'h59, 8'h59); paso();
      set_rtc(8'h09, 8'h00, 8'h00); paso(); paso(); paso();
      chk("cleared after reset", 32'(sonando), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
